// File: rtl/keypad_emulator.sv
// Emulates one mechanical key on a row/column scanned keypad: accepts press commands,
// plays out optional contact bounce, a timed hold, release, and a quiet gap.
module keypad_emulator #(
    parameter int BOUNCE_PERIOD  = 16,
    parameter int BOUNCE_TOGGLES = 4,
    parameter int GAP_CYCLES     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_row,
    output logic [3:0]  cols,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [15:0] cmd_hold,
    input  logic        cmd_bounce,
    output logic        contact,
    output logic        busy
);

    localparam int PW = $clog2(BOUNCE_PERIOD + 1);
    localparam int TW = $clog2(BOUNCE_TOGGLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [PW-1:0] PER_LAST = PW'(BOUNCE_PERIOD - 1);
    localparam logic [TW-1:0] TOG_LAST = TW'(BOUNCE_TOGGLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_BOUNCE,
        HELD,
        RELEASE_BOUNCE,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic          contact_q, contact_d;
    logic [3:0]    key_q, key_d;
    logic [15:0]   hold_q, hold_d;
    logic          bounce_q, bounce_d;
    logic [15:0]   hcnt_q, hcnt_d;
    logic [PW-1:0] per_q, per_d;
    logic [TW-1:0] tog_q, tog_d;
    logic [GW-1:0] gap_q, gap_d;

    logic [15:0] hold_last;
    logic        per_wrap;
    logic        last_tog;

    // A zero hold is stretched to one cycle so the closure is always visible.
    assign hold_last = (hold_q == 16'd0) ? 16'd0 : hold_q - 16'd1;
    assign per_wrap  = (per_q == PER_LAST);
    assign last_tog  = per_wrap && (tog_q == TOG_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            contact_q <= 1'b0;
            key_q     <= '0;
            hold_q    <= '0;
            bounce_q  <= 1'b0;
            hcnt_q    <= '0;
            per_q     <= '0;
            tog_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            contact_q <= contact_d;
            key_q     <= key_d;
            hold_q    <= hold_d;
            bounce_q  <= bounce_d;
            hcnt_q    <= hcnt_d;
            per_q     <= per_d;
            tog_q     <= tog_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        contact_d = contact_q;
        key_d     = key_q;
        hold_d    = hold_q;
        bounce_d  = bounce_q;
        hcnt_d    = hcnt_q;
        per_d     = per_q;
        tog_d     = tog_q;
        gap_d     = gap_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    key_d     = cmd_key;
                    hold_d    = cmd_hold;
                    bounce_d  = cmd_bounce;
                    contact_d = 1'b1;
                    hcnt_d    = '0;
                    per_d     = '0;
                    tog_d     = '0;
                    state_d   = cmd_bounce ? PRESS_BOUNCE : HELD;
                end
            end
            PRESS_BOUNCE, RELEASE_BOUNCE: begin
                per_d = per_wrap ? '0 : per_q + PW'(1);
                if (per_wrap) begin
                    contact_d = ~contact_q;
                    tog_d     = last_tog ? '0 : tog_q + TW'(1);
                end
                // Final level is forced so an odd toggle count still ends in the right state.
                if (last_tog) begin
                    if (state_q == PRESS_BOUNCE) begin
                        contact_d = 1'b1;
                        state_d   = HELD;
                    end else begin
                        contact_d = 1'b0;
                        gap_d     = '0;
                        state_d   = GAP;
                    end
                end
            end
            HELD: begin
                if (hcnt_q == hold_last) begin
                    contact_d = 1'b0;
                    hcnt_d    = '0;
                    per_d     = '0;
                    tog_d     = '0;
                    gap_d     = '0;
                    state_d   = bounce_q ? RELEASE_BOUNCE : GAP;
                end else begin
                    hcnt_d = hcnt_q + 16'd1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = ~cmd_ready;
    assign contact   = contact_q;

    // Live row drive passes straight through so the scanner sees the key in the row it is driving.
    always_comb begin
        cols = 4'b1111;
        if (contact_q)
            cols[key_q[1:0]] = key_row[key_q[3:2]];
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: contact-edge and ready-return scoreboard plus direct cols/reset checks.
module tb_keypad_emulator;

    localparam int P = 16;
    localparam int T = 4;
    localparam int G = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  key_row;
    logic [3:0]  cols;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_key;
    logic [15:0] cmd_hold;
    logic        cmd_bounce;
    logic        contact;
    logic        busy;

    keypad_emulator #(
        .BOUNCE_PERIOD (P),
        .BOUNCE_TOGGLES(T),
        .GAP_CYCLES    (G)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_row   (key_row),
        .cols      (cols),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_key   (cmd_key),
        .cmd_hold  (cmd_hold),
        .cmd_bounce(cmd_bounce),
        .contact   (contact),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic val;
    } ev_t;

    ev_t exp_q[$];
    int  rdy_q[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_err = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // Expected contact edges and ready-return cycle for a press accepted so that
    // contact first reads high in cycle acc.
    task automatic push_press(input int acc, input int hold, input logic bnc);
        int t;
        int heff;
        heff = (hold == 0) ? 1 : hold;
        t = acc;
        push_ev(t, 1'b1);
        if (bnc)
            for (int i = 1; i <= T; i++) begin
                t += P;
                push_ev(t, (i % 2) == 0);
            end
        t += heff;
        push_ev(t, 1'b0);
        if (bnc)
            for (int i = 1; i <= T; i++) begin
                t += P;
                push_ev(t, (i % 2) == 1);
            end
        rdy_q.push_back(t + G);
    endtask

    task automatic drive(input logic [3:0] k, input int h, input logic b);
        cmd_key    = k;
        cmd_hold   = h[15:0];
        cmd_bounce = b;
        cmd_valid  = 1'b1;
    endtask

    task automatic wait_idle(output int rc);
        bit found;
        found = 1'b0;
        rc = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(posedge clk);
            #1;
            if (cmd_ready) begin
                found = 1'b1;
                rc = cyc;
            end
        end
        if (!found)
            chk("idle_timeout", cmd_ready, 1);
    endtask

    // Monitor: pops expectations as contact edges and ready returns appear.
    initial begin
        logic pc;
        logic pr;
        ev_t  e;
        int   r;
        pc = 1'b0;
        pr = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (contact !== pc) begin
                    if (exp_q.size() == 0) begin
                        chk("contact_extra", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("contact_cyc", cyc, e.cyc);
                        chk("contact_val", contact, e.val);
                    end
                end
                if (cmd_ready && !pr) begin
                    if (rdy_q.size() == 0) begin
                        chk("ready_extra", rdy_q.size(), 1);
                    end else begin
                        r = rdy_q.pop_front();
                        chk("ready_cyc", cyc, r);
                    end
                end
            end
            pc = contact;
            pr = cmd_ready;
        end
    end

    initial begin
        int acc;
        int acc2;
        int rc;
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_key    = 4'h0;
        cmd_hold   = 16'd0;
        cmd_bounce = 1'b0;
        key_row    = 4'b1110;

        // Held in reset while the scanner walks the rows.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            key_row = {key_row[2:0], key_row[3]};
            #1;
            chk("rst_cols", cols, 4'b1111);
            chk("rst_ready", cmd_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_contact", contact, 0);
        end

        // Release reset with a command already waiting: accepted on the first edge.
        @(posedge clk);
        #1;
        reset   = 1'b1;
        key_row = 4'b1101;
        drive(4'h6, 10, 1'b0);
        acc = cyc + 1;
        push_press(acc, 10, 1'b0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("clean_acc_cyc", cyc, acc);
        chk("clean_cols", cols, 4'b1011);
        chk("clean_busy", busy, 1);
        repeat (3) @(posedge clk);
        #1;
        key_row = 4'b1110;
        #1;
        chk("follow_other_row", cols, 4'b1111);
        key_row = 4'b1101;
        #1;
        chk("follow_back", cols, 4'b1011);
        wait_idle(rc);
        chk("clean_span", rc - acc, 10 + G);

        // Bounced press on the last key.
        key_row = 4'b0111;
        drive(4'hF, 5, 1'b1);
        acc = cyc + 1;
        push_press(acc, 5, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("bnc_cols_closed", cols, 4'b0111);
        repeat (20) @(posedge clk);
        #1;
        chk("bnc_cols_open", cols, 4'b1111);
        wait_idle(rc);
        // Accept cycle included: 1 + press bounce + hold + release bounce + gap.
        chk("bnc_span", rc - acc + 1, 1 + P * T + 5 + P * T + G);

        // Back-pressure: a command presented during HELD waits for IDLE.
        key_row = 4'b1101;
        drive(4'h6, 10, 1'b0);
        acc = cyc + 1;
        push_press(acc, 10, 1'b0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive(4'h0, 3, 1'b0);
        key_row = 4'b1110;
        acc2 = acc + 10 + G + 1;
        push_press(acc2, 3, 1'b0);
        #1;
        chk("bp_ready_low", cmd_ready, 0);
        for (int k = 0; k < 200 && cyc < acc2; k++) begin
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("bp_acc_cyc", cyc, acc2);
        chk("bp_cols", cols, 4'b1110);
        wait_idle(rc);

        // Abort mid-hold: outputs drop immediately, no gap afterwards.
        key_row = 4'b1101;
        drive(4'h5, 100, 1'b0);
        acc = cyc + 1;
        push_press(acc, 100, 1'b0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_cols_before", cols, 4'b1101);
        exp_q.delete();
        rdy_q.delete();
        reset = 1'b0;
        #1;
        chk("abort_contact", contact, 0);
        chk("abort_cols", cols, 4'b1111);
        chk("abort_busy", busy, 0);
        chk("abort_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("post_abort_ready", cmd_ready, 1);

        // Zero hold is stretched to a single closed cycle.
        drive(4'h1, 0, 1'b0);
        acc = cyc + 1;
        push_press(acc, 0, 1'b0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("hold0_contact", contact, 1);
        wait_idle(rc);
        chk("hold0_span", rc - acc, 1 + G);

        repeat (3) @(posedge clk);
        #1;
        chk("events_left", exp_q.size(), 0);
        chk("ready_left", rdy_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 SHALL have parameter BOUNCE_PERIOD, default 16, cycles between contact toggles during a bounce phase (>=1).
REQ-002 SHALL have parameter BOUNCE_TOGGLES, default 4, toggles per bounce phase (even, >=2).
REQ-003 SHALL have parameter GAP_CYCLES, default 64, minimum open-contact cycles after a release before the next command is accepted (>=1).
REQ-004 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port key_row  input  4  row drive from the keypad scanner; active-low, at most one bit low.
REQ-007 SHALL have port cols  output  4  emulated column lines; active-low, idle 4'b1111.
REQ-008 SHALL have port cmd_valid  input  1  press command present.
REQ-009 SHALL have port cmd_ready  output  1  emulator can accept a command.
REQ-010 SHALL have port cmd_key  input  4  key index; row = cmd_key[3:2], column = cmd_key[1:0].
REQ-011 SHALL have port cmd_hold  input  16  cycles of stable closure after press bounce.
REQ-012 SHALL have port cmd_bounce  input  1  1 = bounce phases enabled for this press.
REQ-013 SHALL have port contact  output  1  current switch closure state (1 = closed).
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1, latching cmd_key, cmd_hold and cmd_bounce.
REQ-016 SHALL assert cmd_ready only in IDLE; cmd_valid outside IDLE is ignored and not queued.
REQ-017 SHALL implement states IDLE, PRESS_BOUNCE, HELD, RELEASE_BOUNCE, GAP.
REQ-018 SHALL transition IDLE -> PRESS_BOUNCE on accept with cmd_bounce=1, IDLE -> HELD on accept with cmd_bounce=0.
REQ-019 SHALL set contact=1 in the cycle after accept (latency 1) for both paths.
REQ-020 SHALL, in PRESS_BOUNCE, invert contact every BOUNCE_PERIOD cycles, BOUNCE_TOGGLES times, contact=1 after the last toggle, then enter HELD.
REQ-021 SHALL hold contact=1 in HELD for exactly max(cmd_hold,1) cycles; cmd_hold=0 is treated as 1.
REQ-022 SHALL leave HELD with contact=0 and enter RELEASE_BOUNCE (latched bounce=1) or GAP (latched bounce=0).
REQ-023 SHALL, in RELEASE_BOUNCE, invert contact every BOUNCE_PERIOD cycles, BOUNCE_TOGGLES times, contact=0 after the last toggle, then enter GAP.
REQ-024 SHALL hold contact=0 in GAP for GAP_CYCLES cycles, then enter IDLE.
REQ-025 SHALL drive cols[c] = key_row[r] for the latched row r and column c while contact=1, all other cols bits 1; cols=4'b1111 while contact=0.
REQ-026 SHALL compute cols combinationally from registered contact/key and live key_row, so row scanning is reflected in the same cycle.
REQ-027 SHALL use a 16-bit hold counter and counters sized for the parameters; no counter wraps within a phase.
REQ-028 SHALL leave cmd_key values with row and column out of the decoded range impossible (all 16 indices map to a unique row/column).

Reset
REQ-029 SHALL, while reset=0, force state IDLE, contact=0, cols=4'b1111, busy=0, cmd_ready=1 and clear all counters and latched fields, asynchronously.
REQ-030 SHALL, on reset assertion mid-press (any non-IDLE state), abort immediately with cols=4'b1111 and no GAP phase.
REQ-031 SHALL accept a command on the first rising edge after reset deassertion if cmd_valid=1.

Verification
REQ-032 Reset then idle: reset=0 for 3 cycles, key_row scanning -> cols=4'b1111, cmd_ready=1, busy=0 throughout.
REQ-033 Clean press: cmd_key=4'h6, cmd_hold=10, cmd_bounce=0, key_row=4'b1101 -> contact=1 for cycles 1..10 after accept, cols=4'b1011 in those cycles, cmd_ready returns 1 after 64 gap cycles.
REQ-034 Row-follow: same press with key_row=4'b1110 during hold -> cols=4'b1111; switching key_row to 4'b1101 changes cols to 4'b1011 in the same cycle.
REQ-035 Bounced press: cmd_key=4'hF, cmd_hold=5, cmd_bounce=1, defaults -> 4 contact toggles 16 cycles apart on press, 5 stable cycles, 4 toggles on release, total busy = 1+64+5+64+64 cycles.
REQ-036 Back-pressure: cmd_valid held high during HELD with cmd_key=4'h0 -> ignored; accepted only on first IDLE cycle.
REQ-037 Abort: reset=0 asserted mid-HELD -> cols=4'b1111 and contact=0 before the next clock edge; cmd_ready=1 after release.
